// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   XLEN     : register data width
//   NREG     : number of architectural registers (x0 hardwired to zero)
//   RA_W     : register address width
//   ZERO_REG : address of the hardwired-zero register
//   wb_req_t : one pending writeback (destination register + data)
package rf_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RA_W = $clog2(NREG);

  localparam logic [RA_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular FIFO buffering memory-path writeback requests.
//   clk, rst_n    : clock, asynchronous active-low reset (clears pointers/count)
//   push_i        : write push_data_i at the tail (ignored when full without pop)
//   push_data_i   : request to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry, valid when empty_o is low
//   count_o       : number of stored entries
//   full_o/empty_o: occupancy flags
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_req_t          push_data_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer increment wrapping at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO can still take a push when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the ALU result path
// (never stalled, highest priority) and the memory/load path (buffered in a
// small FIFO, back-pressured via mem_ready). Tracks pending writes in a busy
// scoreboard and stalls issue on RAW/WAW hazards.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   issue_valid/rs1/rs2/rd             : instruction presented by decode
//   issue_stall                        : combinational hazard stall to decode
//   alu_valid/alu_rd/alu_data          : ALU writeback (cannot be held off)
//   mem_valid/mem_rd/mem_data          : memory writeback offer
//   mem_ready                          : combinational FIFO accept
//   rf_regwrite/rf_write_reg/_data     : registered write port to reg_file
//   busy_vec                           : registered scoreboard, bit 0 always 0
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned MEM_BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [RA_W-1:0] issue_rs1,
  input  logic [RA_W-1:0] issue_rs2,
  input  logic [RA_W-1:0] issue_rd,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_regwrite,
  output logic [RA_W-1:0] rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  output logic [NREG-1:0] busy_vec
);

  localparam int unsigned CNT_W = $clog2(MEM_BUF_DEPTH + 1);

  wb_req_t          mem_req;
  wb_req_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             mem_accept;
  logic             mem_bypass;

  logic             wr_valid;
  wb_req_t          wr_req;

  logic             rf_regwrite_q, rf_regwrite_d;
  logic [RA_W-1:0]  rf_write_reg_q, rf_write_reg_d;
  logic [XLEN-1:0]  rf_write_data_q, rf_write_data_d;
  logic [NREG-1:0]  busy_q, busy_d;

  assign mem_req.rd   = mem_rd;
  assign mem_req.data = mem_data;

  rf_wb_fifo #(
    .DEPTH (MEM_BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (mem_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Hazard stall against any pending write; busy_q[0] is never set.
  assign issue_stall = issue_valid &
                       (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

  // Head leaves whenever the ALU does not claim the port.
  assign fifo_pop  = ~alu_valid & ~fifo_empty;
  assign mem_ready = (fifo_count < CNT_W'(MEM_BUF_DEPTH)) | (fifo_full & fifo_pop);

  // An idle port with an empty FIFO lets a fresh memory result skip storage.
  assign mem_accept = mem_valid & mem_ready;
  assign mem_bypass = mem_accept & ~alu_valid & fifo_empty;
  assign fifo_push  = mem_accept & ~mem_bypass;

  // Write-port arbitration: ALU, then FIFO head, then bypassed memory result.
  always_comb begin
    wr_valid = 1'b0;
    wr_req   = '0;
    if (alu_valid) begin
      wr_valid    = 1'b1;
      wr_req.rd   = alu_rd;
      wr_req.data = alu_data;
    end else if (!fifo_empty) begin
      wr_valid = 1'b1;
      wr_req   = fifo_head;
    end else if (mem_bypass) begin
      wr_valid = 1'b1;
      wr_req   = mem_req;
    end
  end

  // Port and scoreboard next state; a same-edge set beats the clear.
  always_comb begin
    rf_regwrite_d   = wr_valid & (wr_req.rd != ZERO_REG);
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    busy_d          = busy_q;
    if (wr_valid) begin
      rf_write_reg_d  = wr_req.rd;
      rf_write_data_d = wr_req.data;
    end
    if (wr_valid && (wr_req.rd != ZERO_REG)) busy_d[wr_req.rd] = 1'b0;
    if (issue_valid && !issue_stall && (issue_rd != ZERO_REG)) busy_d[issue_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_regwrite_q   <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      busy_q          <= '0;
    end else begin
      rf_regwrite_q   <= rf_regwrite_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign rf_regwrite   = rf_regwrite_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;
  assign busy_vec      = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, hand-written
// FIFO-full and mid-burst reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int D = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [RA_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic            issue_stall;
  logic            alu_valid;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            rf_regwrite;
  logic [RA_W-1:0] rf_write_reg;
  logic [XLEN-1:0] rf_write_data;
  logic [NREG-1:0] busy_vec;

  rf_wb_arbiter #(.MEM_BUF_DEPTH(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_stall   (issue_stall),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .rf_regwrite   (rf_regwrite),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .busy_vec      (busy_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: scoreboard bits, FIFO as a queue, expected port values.
  logic [NREG-1:0] m_busy;
  wb_req_t         m_q[$];
  logic            m_we;
  logic [RA_W-1:0] m_reg;
  logic [XLEN-1:0] m_data;
  logic            s_stall, s_ready;

  task automatic model_reset();
    m_busy = '0;
    m_q.delete();
    m_we = 1'b0;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  // One clock with inputs already driven: check combinational outputs at the
  // falling edge, advance the model, check registered outputs after the edge.
  task automatic cycle(input string tag);
    wb_req_t w, mreq;
    logic    wv, acc, byp, pop, stall_m, ready_m;
    int      sz;
    @(negedge clk);
    sz      = m_q.size();
    pop     = !alu_valid && sz > 0;
    ready_m = (sz < D) || (sz == D && pop);
    stall_m = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
    s_stall = issue_stall;
    s_ready = mem_ready;
    chk({tag, " stall"}, 32'(issue_stall), 32'(stall_m));
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(ready_m));
    mreq.rd = mem_rd; mreq.data = mem_data;
    acc = mem_valid && ready_m;
    byp = 1'b0; wv = 1'b0; w = '0;
    if (alu_valid) begin
      wv = 1'b1; w.rd = alu_rd; w.data = alu_data;
    end else if (sz > 0) begin
      wv = 1'b1; w = m_q.pop_front();
    end else if (acc) begin
      wv = 1'b1; w = mreq; byp = 1'b1;
    end
    if (acc && !byp) m_q.push_back(mreq);
    if (wv && w.rd != 0) m_busy[w.rd] = 1'b0;
    if (issue_valid && !stall_m && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_we = wv && (w.rd != 0);
    m_reg = w.rd;
    m_data = w.data;
    @(posedge clk);
    #1;
    chk({tag, " regwrite"}, 32'(rf_regwrite), 32'(m_we));
    if (m_we) begin
      chk({tag, " write_reg"}, 32'(rf_write_reg), 32'(m_reg));
      chk({tag, " write_data"}, rf_write_data, m_data);
    end
    chk({tag, " busy_vec"}, busy_vec, m_busy);
  endtask

  typedef struct {
    logic iv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic mv; logic [4:0] mrd; logic [31:0] mdat;
    logic stall; logic ready; logic we; logic [4:0] wreg; logic [31:0] wdat;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // RAW stall on x5, port conflict x3/x4, x0 results, same-edge set/clear on x7
    tbl[0] = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h20};
    tbl[1] = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h20};
    tbl[2] = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h40};
    tbl[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b1, 5'd3, 32'h11,       32'h40};
    tbl[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd4, 32'h22,       32'h40};
    tbl[6] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h40};
    tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h40};
    tbl[8] = '{1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd7, 32'h77,       32'hC0};
    tbl[9] = '{1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd6, 32'h66,       32'h80};

    // Power-on reset values while rst_n is low.
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("reset regwrite", 32'(rf_regwrite), 32'h0);
    chk("reset write_reg", 32'(rf_write_reg), 32'h0);
    chk("reset write_data", rf_write_data, 32'h0);
    chk("reset busy_vec", busy_vec, 32'h0);
    chk("reset mem_ready", 32'(mem_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      issue_valid = tbl[i].iv; issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2; issue_rd = tbl[i].rd;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl stall", i), 32'(s_stall), 32'(tbl[i].stall));
      chk($sformatf("vec%0d tbl ready", i), 32'(s_ready), 32'(tbl[i].ready));
      chk($sformatf("vec%0d tbl regwrite", i), 32'(rf_regwrite), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("vec%0d tbl write_reg", i), 32'(rf_write_reg), 32'(tbl[i].wreg));
        chk($sformatf("vec%0d tbl write_data", i), rf_write_data, tbl[i].wdat);
      end
      chk($sformatf("vec%0d tbl busy", i), busy_vec, tbl[i].busy);
    end
    idle_inputs();

    // FIFO full: ALU holds the port for 4 cycles while 3 memory results wait.
    begin
      logic [31:0] mdat [3];
      logic [4:0]  mrd  [3];
      logic        exp_rdy [8];
      logic [4:0]  exp_reg [8];
      logic [31:0] exp_dat [8];
      int          idx;
      mdat = '{32'hB0, 32'hB1, 32'hB2};
      mrd  = '{5'd10, 5'd11, 5'd12};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_reg = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12, 5'd0};
      exp_dat = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB0, 32'hB1, 32'hB2, 32'h0};
      idx = 0;
      for (int c = 0; c < 8; c++) begin
        alu_valid = (c < 4);
        alu_rd    = (c < 4) ? 5'(c + 1) : 5'd0;
        alu_data  = 32'hA1 + 32'(c);
        mem_valid = (idx < 3);
        mem_rd    = (idx < 3) ? mrd[idx] : 5'd0;
        mem_data  = (idx < 3) ? mdat[idx] : 32'h0;
        cycle($sformatf("full%0d", c));
        if (mem_valid && s_ready) idx++;
        chk($sformatf("full%0d ready", c), 32'(s_ready), 32'(exp_rdy[c]));
        chk($sformatf("full%0d regwrite", c), 32'(rf_regwrite), 32'(c < 7));
        if (c < 7) begin
          chk($sformatf("full%0d write_reg", c), 32'(rf_write_reg), 32'(exp_reg[c]));
          chk($sformatf("full%0d write_data", c), rf_write_data, exp_dat[c]);
        end
      end
      idle_inputs();
    end

    // Mid-burst reset with two buffered memory results and a busy register.
    issue_valid = 1'b1; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hC1;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD1;
    cycle("prerst0");
    issue_valid = 1'b0; issue_rd = 5'd0;
    alu_rd = 5'd2; alu_data = 32'hC2;
    mem_rd = 5'd14; mem_data = 32'hD2;
    cycle("prerst1");
    alu_rd = 5'd3; alu_data = 32'hC3;
    mem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy_vec", busy_vec, 32'h0);
    chk("midrst regwrite", 32'(rf_regwrite), 32'h0);
    chk("midrst mem_ready", 32'(mem_ready), 32'h1);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle($sformatf("postrst%0d", c));

    // Randomized traffic on a small register window to provoke hazards.
    for (int c = 0; c < 500; c++) begin
      issue_valid = ($urandom_range(99) < 50);
      issue_rs1   = 5'($urandom_range(7));
      issue_rs2   = 5'($urandom_range(7));
      issue_rd    = 5'($urandom_range(7));
      alu_valid   = ($urandom_range(99) < 40);
      alu_rd      = 5'($urandom_range(7));
      alu_data    = 32'($urandom);
      mem_valid   = ($urandom_range(99) < 50);
      mem_rd      = 5'($urandom_range(7));
      mem_data    = 32'($urandom);
      cycle("rnd");
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle("drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - the single-cycle ALU result path, which cannot be back-pressured;
  - the variable-latency memory/load path, which can be back-pressured.
- Keeps a per-register busy scoreboard and raises an issue stall on RAW and WAW hazards against pending writes.
- Sits between the execute/memory stages and reg_file. Drives reg_file's regwrite, write_reg and write_data.

Parameters:
- XLEN, 32, data width of register values.
- NREG, 32, number of architectural registers. x0 is hardwired to zero.
- RA_W, 5, register address width, equal to $clog2(NREG).
- MEM_BUF_DEPTH, 2, depth of the memory-result FIFO. Legal values: 1..4.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs1  in  RA_W  source register 1 of the issuing instruction
- issue_rs2  in  RA_W  source register 2 of the issuing instruction
- issue_rd  in  RA_W  destination register; 0 means no write
- issue_stall  out  1  hold decode; hazard on a busy register
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  RA_W  ALU destination register
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  memory result offered
- mem_rd  in  RA_W  memory destination register
- mem_data  in  XLEN  memory result
- mem_ready  out  1  FIFO can accept this cycle
- rf_regwrite  out  1  to reg_file regwrite
- rf_write_reg  out  RA_W  to reg_file write_reg
- rf_write_data  out  XLEN  to reg_file write_data
- busy_vec  out  NREG  scoreboard, for debug and forwarding

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_regwrite=0, rf_write_reg=0, rf_write_data=0.
  - busy_vec=0, FIFO count=0, FIFO pointers=0.
  - mem_ready=1 while in reset.
  - Reset mid-operation discards all FIFO contents and all busy bits with no commit.
- Hazard check:
  - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), combinational.
  - busy[0] is constant 0.
- Scoreboard set: on a rising edge with issue_valid & ~issue_stall & (issue_rd≠0), set busy[issue_rd].
- Scoreboard clear: clear busy[r] on the edge where the write to r is registered onto the rf_* port.
- Set and clear of the same register on the same edge: set wins, because a new pending write exists.
- Write-port arbitration, evaluated each cycle:
  - alu_valid=1: ALU wins. On the next edge rf_regwrite←1, rf_write_reg←alu_rd, rf_write_data←alu_data.
  - alu_valid=0 and FIFO not empty: pop the head and register it onto rf_* the same way.
  - Otherwise rf_regwrite←0. rf_write_reg and rf_write_data hold their previous values.
- Write latency:
  - ALU results reach the rf port 1 cycle after alu_valid. reg_file commits them on the following falling edge.
  - Memory results take ≥1 cycle after acceptance; FIFO ordering is strict.
  - Memory results bypass the FIFO storage only when the FIFO is empty and alu_valid=0. Acceptance and port write then happen at the same edge, giving 1-cycle latency.
- rd=0 results:
  - Accepted and consumed normally, with rf_regwrite forced to 0 for that slot.
  - No busy bit is touched.
- FIFO:
  - mem_ready = (count < MEM_BUF_DEPTH), or (count == MEM_BUF_DEPTH and a pop occurs this cycle).
  - Push when mem_valid & mem_ready.
  - Simultaneous push and pop keep count unchanged.
  - Pointers wrap modulo MEM_BUF_DEPTH.
- Protocol error: mem_valid while mem_ready=0 is a protocol error. The data is ignored, with no state change.
- Starvation: continuous alu_valid starves the FIFO. This is permitted. Upstream bounds the ALU burst length.

Decomposition:
- Package rf_pkg holds:
  - XLEN, NREG, RA_W;
  - typedef wb_req_t {rd, data};
  - the constant ZERO_REG=0.
- One sub-module: rf_wb_fifo, parameterised by depth and carrying wb_req_t. It provides push/pop, count, full and empty.
- Arbitration and the scoreboard stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-burst with FIFO count=2 -> the same cycle shows busy_vec=0, rf_regwrite=0, mem_ready=1; no later write of the discarded entries.
- RAW stall: issue rd=5 → next cycle issue rs1=5 -> issue_stall=1 until ALU writes x5 (alu_rd=5, data=0xDEADBEEF); rf_* shows x5/0xDEADBEEF one cycle after alu_valid; stall drops the cycle after.
- Port conflict: alu_valid and mem_valid in the same cycle (alu_rd=3/0x11, mem_rd=4/0x22) -> rf writes x3=0x11, then x4=0x22 on the next cycle; mem_ready stays 1.
- FIFO full: alu_valid held for 4 cycles while 3 memory results are offered, depth 2 -> mem_ready=0 after 2 pushes; results drain in order after the ALU stops, with no loss.
- x0 handling: ALU and memory results to rd=0 -> rf_regwrite=0 on their slots; busy_vec unchanged; issue with rd=0 never stalls on rd.
- Same-edge set/clear: ALU commit of x7 on the same edge as a new issue with rd=7 -> busy[7] remains 1.
